// File: rtl/router_pkg.sv
// Shared definitions for the 4-in/4-out routing datapath.
// Holds port-count and select widths, the head-word dest field position,
// the scheduler state encoding and a small one-hot helper.
package router_pkg;

    localparam int NPORT    = 4;
    localparam int SEL_W    = 2;
    localparam int DATA_W   = 10;
    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    function automatic logic [NPORT-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NPORT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches elig in the order ptr+1, ptr+2, ptr+3, ptr (mod NPORT) and
// returns the first hit.
// Ports:
//   elig  in  NPORT  request mask, bit i = requester i
//   ptr   in  SEL_W  index of the last winner
//   grant out SEL_W  chosen index (0 when nothing is found)
//   found out 1      at least one requester present
module rr_pick
    import router_pkg::*;
(
    input  logic [NPORT-1:0] elig,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             found
);

    // Walk the search order backwards so the nearest candidate after ptr
    // is the last assignment and therefore wins. k = NPORT wraps to ptr.
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NPORT; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (elig[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sched.sv
// Round-robin scheduler for the 4-input/4-output routing datapath.
// Picks an input FIFO whose head word can be delivered (input non-empty and
// target output not full), pops it, then pushes the word into the output
// FIFO named by the head word dest field one cycle later. One word per two
// cycles at most.
// Optional build macro RR_SCHED_STATS_EN adds per-input grant counters.
// Ports:
//   clk        in  1   clock, rising edge
//   reset      in  1   asynchronous reset, active low
//   stats_clr  in  1   (RR_SCHED_STATS_EN) synchronous clear of grant_cnt
//   grant_cnt  out 32  (RR_SCHED_STATS_EN) byte i = saturating grants to input i
//   active     in  1   enables new grants
//   in_empty   in  4   input FIFO empty flags
//   head_dest  in  8   dest field of each input head word, 2 bits per input
//   out_full   in  4   output FIFO full flags
//   pop        out 4   one-hot input FIFO read strobe
//   push       out 4   one-hot output FIFO write strobe
//   demux0     out 2   datapath source select
//   dest       out 2   datapath destination select
//   busy       out 1   transfer in flight
module rr_sched
    import router_pkg::*;
#(
    parameter logic [SEL_W-1:0] RST_PTR = 2'd3
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef RR_SCHED_STATS_EN
    input  logic                   stats_clr,
    output logic [31:0]            grant_cnt,
`endif
    input  logic                   active,
    input  logic [NPORT-1:0]       in_empty,
    input  logic [NPORT*SEL_W-1:0] head_dest,
    input  logic [NPORT-1:0]       out_full,
    output logic [NPORT-1:0]       pop,
    output logic [NPORT-1:0]       push,
    output logic [SEL_W-1:0]       demux0,
    output logic [SEL_W-1:0]       dest,
    output logic                   busy
);

    sched_state_t     state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx;
    logic [NPORT-1:0] elig;
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             grant_fire;
    logic [NPORT-1:0] pop_nx, push_nx;
    logic [SEL_W-1:0] demux0_nx, dest_nx;
    logic             busy_nx;

    // The dest field of an empty input may be garbage; mask it out before
    // it can index out_full.
    always_comb begin
        logic [SEL_W-1:0] dsel;
        elig = '0;
        dsel = '0;
        for (int i = 0; i < NPORT; i++) begin
            dsel    = head_dest[SEL_W*i +: SEL_W];
            elig[i] = in_empty[i] ? 1'b0 : !out_full[dsel];
        end
    end

    rr_pick u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .found (found)
    );

    assign grant_fire = (state == IDLE) && active && found;

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        pop_nx    = '0;
        push_nx   = '0;
        demux0_nx = demux0;
        dest_nx   = dest;
        busy_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    pop_nx    = onehot(grant);
                    demux0_nx = grant;
                    dest_nx   = head_dest[{grant, 1'b0} +: SEL_W];
                    ptr_nx    = grant;
                    busy_nx   = 1'b1;
                    state_nx  = XFER;
                end
            end
            XFER: begin
                // Popped word is on the FIFO output now; write it out.
                push_nx  = onehot(dest);
                busy_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= RST_PTR;
            pop    <= '0;
            push   <= '0;
            demux0 <= '0;
            dest   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            pop    <= pop_nx;
            push   <= push_nx;
            demux0 <= demux0_nx;
            dest   <= dest_nx;
            busy   <= busy_nx;
        end
    end

`ifdef RR_SCHED_STATS_EN
    logic [NPORT-1:0][7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (stats_clr) begin
            cnt <= '0;
        end else if (grant_fire && cnt[grant] != 8'hFF) begin
            cnt[grant] <= cnt[grant] + 8'd1;
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_rr_sched.sv
// Scoreboard bench for rr_sched: directed stimulus queues expected pop/push
// events; a negedge monitor compares every strobe the DUT raises. A small
// FIFO model feeds in_empty/head_dest and consumes words on pop.
module tb_rr_sched;
    import router_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic [3:0] in_empty;
    logic [7:0] head_dest;
    logic [3:0] out_full;
    logic [3:0] pop, push;
    logic [1:0] demux0, dest;
    logic       busy;
`ifdef RR_SCHED_STATS_EN
    logic        stats_clr;
    logic [31:0] grant_cnt;
`endif

    rr_sched dut (
        .clk       (clk),
        .reset     (reset),
`ifdef RR_SCHED_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .active    (active),
        .in_empty  (in_empty),
        .head_dest (head_dest),
        .out_full  (out_full),
        .pop       (pop),
        .push      (push),
        .demux0    (demux0),
        .dest      (dest),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_push;
        logic [3:0] vec;
        logic [1:0] src;
        logic [1:0] d;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   last_pop_cyc = -100;
    int   dest_mem[4][512];
    int   rd[4];
    int   wr[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Drive FIFO flags from the bench model; empty inputs get a dest that
    // would hit a full output if it were not ignored.
    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            in_empty[i] = (rd[i] == wr[i]);
            head_dest[2*i +: 2] = in_empty[i] ? 2'd3 : 2'(dest_mem[i][rd[i]]);
        end
    endtask

    task automatic load(input int i, input int d);
        dest_mem[i][wr[i]] = d;
        wr[i]++;
    endtask

    task automatic exp_pop(input int s, input int d, input int gap);
        exp_t e;
        e.is_push = 1'b0;
        e.vec     = 4'(1 << s);
        e.src     = 2'(s);
        e.d       = 2'(d);
        e.gap     = gap;
        q.push_back(e);
    endtask

    task automatic exp_xfer(input int s, input int d, input int gap);
        exp_t e;
        exp_pop(s, d, gap);
        e.is_push = 1'b1;
        e.vec     = 4'(1 << d);
        e.src     = 2'(s);
        e.d       = 2'(d);
        e.gap     = -1;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int lim, input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < lim; k++) begin
            tick();
            if (q.size() == 0 && busy == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: timeout, %0d expected events left, required 0", nm, q.size());
        end
    endtask

    // FIFO model: consume the head word of every popped input.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (pop[i] && rd[i] != wr[i]) rd[i]++;
            refresh();
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (pop != 4'b0) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pop: got pop=%b, required no strobe", pop);
                end else begin
                    e  = q.pop_front();
                    ok = !e.is_push && pop == e.vec && demux0 == e.src && dest == e.d &&
                         (e.gap < 0 || cyc - last_pop_cyc == e.gap);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL pop_event: got pop=%b demux0=%0d dest=%0d gap=%0d, required %s=%b demux0=%0d dest=%0d gap=%0d",
                                 pop, demux0, dest, cyc - last_pop_cyc,
                                 e.is_push ? "push" : "pop", e.vec, e.src, e.d, e.gap);
                    end
                end
                last_pop_cyc = cyc;
            end
            if (push != 4'b0) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_push: got push=%b, required no strobe", push);
                end else begin
                    e  = q.pop_front();
                    ok = e.is_push && push == e.vec && demux0 == e.src && dest == e.d &&
                         cyc == last_pop_cyc + 1;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL push_event: got push=%b demux0=%0d dest=%0d lag=%0d, required %s=%b demux0=%0d dest=%0d lag=1",
                                 push, demux0, dest, cyc - last_pop_cyc,
                                 e.is_push ? "push" : "pop", e.vec, e.src, e.d);
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        reset    = 1'b1;
        active   = 1'b0;
        out_full = 4'b0;
`ifdef RR_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        refresh();
        #2 reset = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_sel", 32'({demux0, dest}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // All empty: nothing moves
        reset  = 1'b1;
        active = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_quiet", 32'({pop, push, busy, demux0, dest}), 32'h0);
        end

        // Round-robin order from reset pointer: 0,1,2,3,0 every 2 cycles
        active = 1'b0;
        exp_xfer(0, 3, -1);
        exp_xfer(1, 2, 2);
        exp_xfer(2, 1, 2);
        exp_xfer(3, 0, 2);
        exp_xfer(0, 2, 2);
        load(0, 3); load(0, 2); load(1, 2); load(2, 1); load(3, 0);
        refresh();
        tick();
        active = 1'b1;
        wait_drain(100, "rr_order");
        chk("hold_sel", 32'({demux0, dest}), 32'({2'd0, 2'd2}));

        // Single input 2 with dest 1
        exp_xfer(2, 1, -1);
        load(2, 1);
        refresh();
        wait_drain(50, "single_in2");

        // Target output full: no pop until it clears, then input 0 first
        out_full = 4'b0100;
        load(0, 2); load(1, 2);
        refresh();
        repeat (10) tick();
        chk("blocked_full", 32'({pop, busy}), 32'h0);
        exp_xfer(0, 2, -1);
        exp_xfer(1, 2, 2);
        out_full = 4'b0;
        wait_drain(50, "unblock");

        // Input 0 blocked on full output 3 is skipped, input 1 goes
        out_full = 4'b1000;
        exp_xfer(1, 0, -1);
        load(0, 3); load(1, 0);
        refresh();
        wait_drain(50, "skip_blocked");
        repeat (4) tick();
        exp_xfer(0, 3, -1);
        out_full = 4'b0;
        wait_drain(50, "late_in0");

        // Reset during XFER drops the push; search restarts at input 0
        exp_pop(1, 2, -1);
        load(0, 1); load(1, 2); load(2, 0);
        refresh();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pop[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_xfer_pop_seen", 32'(seen), 32'h1);
        tick();
        chk("push_before_rst", 32'(push), 32'h4);
        reset = 1'b0;
        #1;
        chk("async_rst_out", 32'({pop, push, busy, demux0, dest}), 32'h0);
        tick();
        exp_xfer(0, 1, -1);
        exp_xfer(2, 0, 2);
        reset = 1'b1;
        wait_drain(50, "after_rst");

`ifdef RR_SCHED_STATS_EN
        // Saturating grant counter and clear
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("cnt_rst", grant_cnt, 32'h0);
        for (int k = 0; k < 300; k++) begin
            exp_xfer(1, 1, (k == 0) ? -1 : 2);
            load(1, 1);
        end
        refresh();
        wait_drain(1000, "stats_300");
        chk("cnt_sat", grant_cnt, 32'h0000FF00);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt_clr", grant_cnt, 32'h0);
`endif

        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
